// File: rtl/r16_fft_pkg.sv
// Shared types and phase lengths for the radix-16 65536-point FFT sequencer.
package r16_fft_pkg;
  localparam int LOAD_LEN   = 4096;
  localparam int UNLOAD_LEN = 4096;
  localparam int STAGE_LEN  = 4096;
  localparam int NUM_STAGES = 4;
  localparam int FLUSH_LEN  = 48;
  localparam int COMP_LEN   = NUM_STAGES * STAGE_LEN + FLUSH_LEN;
  localparam int CNT_WIDTH  = 15;
  localparam int STG_WIDTH  = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // Last counter value of each counted phase; phases without a count use 0.
  function automatic logic [CNT_WIDTH-1:0] phase_last(input state_e s);
    case (s)
      S_LOAD:    phase_last = CNT_WIDTH'(LOAD_LEN - 1);
      S_COMPUTE: phase_last = CNT_WIDTH'(COMP_LEN - 1);
      S_UNLOAD:  phase_last = CNT_WIDTH'(UNLOAD_LEN - 1);
      default:   phase_last = '0;
    endcase
  endfunction
endpackage

// File: rtl/r16_phase_cnt.sv
// Up-counter with synchronous clear (priority over enable) and terminal-count flag.
module r16_phase_cnt #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == last);
endmodule

// File: rtl/r16_fft_seq_ctrl.sv
// Transform sequencer: load -> 4-stage compute with flush -> unload -> done pulse.
module r16_fft_seq_ctrl
  import r16_fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic                 agu_en,
  output logic                 rc_sel,
  output logic                 wrfd_en,
  output logic                 fft_fin,
  output logic [STG_WIDTH-1:0] stage_idx,
  output logic                 busy,
  output logic                 done
);
  state_e               state_q, state_d;
  logic                 cnt_clr, cnt_en, cnt_tc;
  logic [CNT_WIDTH-1:0] cnt, cnt_last;
  logic                 in_load, in_comp, in_unl, load_xfer, unl_xfer;

  assign in_load   = (state_q == S_LOAD);
  assign in_comp   = (state_q == S_COMPUTE);
  assign in_unl    = (state_q == S_UNLOAD);
  assign load_xfer = in_load & in_valid;
  assign unl_xfer  = in_unl & out_ready;
  assign cnt_last  = phase_last(state_q);

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    // abort outranks every phase transition, including a completing one
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d = S_LOAD;
          cnt_clr = 1'b1;
        end
        S_LOAD: if (load_xfer) begin
          if (cnt_tc) begin
            state_d = S_COMPUTE;
            cnt_clr = 1'b1;
          end else cnt_en = 1'b1;
        end
        S_COMPUTE: begin
          if (cnt_tc) begin
            state_d = S_UNLOAD;
            cnt_clr = 1'b1;
          end else cnt_en = 1'b1;
        end
        S_UNLOAD: if (unl_xfer) begin
          if (cnt_tc) begin
            state_d = S_DONE;
            cnt_clr = 1'b1;
          end else cnt_en = 1'b1;
        end
        S_DONE:  state_d = S_IDLE;
        default: begin
          state_d = S_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  r16_phase_cnt #(.W(CNT_WIDTH)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .last  (cnt_last),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  assign rc_sel    = in_load;
  assign in_ready  = in_load;
  assign out_valid = in_unl;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign agu_en    = load_xfer | in_comp;
  assign wrfd_en   = unl_xfer;
  // Counter bits above the stage length select the stage; the flush tail reads as 4.
  assign stage_idx = in_comp ? STG_WIDTH'(cnt / CNT_WIDTH'(STAGE_LEN)) : '0;
  assign fft_fin   = in_comp && (stage_idx == STG_WIDTH'(NUM_STAGES - 1));
endmodule

// File: tb/tb_r16_fft_seq_ctrl.sv
// Directed bench for r16_fft_seq_ctrl: decode table plus full-transform, abort and reset sequences.
module tb_r16_fft_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, start, abort, in_valid, out_ready;
  logic       in_ready, out_valid, agu_en, rc_sel, wrfd_en, fft_fin, busy, done;
  logic [2:0] stage_idx;
  logic [10:0] outs;

  int checks = 0;
  int errors = 0;

  r16_fft_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
    .out_valid(out_valid), .agu_en(agu_en), .rc_sel(rc_sel), .wrfd_en(wrfd_en),
    .fft_fin(fft_fin), .stage_idx(stage_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign outs = {in_ready, out_valid, agu_en, rc_sel, wrfd_en, fft_fin, stage_idx, busy, done};

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic ir, ov, ae, rc, bz, dn);
    mk = {ir, ov, ae, rc, 1'b0, 1'b0, 3'b000, bz, dn};
  endfunction

  typedef struct {
    logic        start, abort, in_valid, out_ready;
    logic [10:0] exp;
  } vec_t;
  vec_t vt[12];

  int load_pulses, load_cyc, load_bad;
  int comp_cyc, fin_cnt, flush_cnt, stg_bad, agu_bad;
  int unl_cyc, wr_cnt, wr_bad;

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // toggle: in_valid low on even cycles, high on odd; hold_start keeps start asserted
  task automatic run_load(input bit toggle, input bit hold_start);
    load_pulses = 0; load_cyc = 0; load_bad = 0;
    while (in_ready && load_cyc < 20000) begin
      in_valid = toggle ? (load_cyc % 2 == 1) : 1'b1;
      start    = hold_start;
      #1;
      if (agu_en) load_pulses++;
      if (!rc_sel || stage_idx != 0 || fft_fin || agu_en != in_valid) load_bad++;
      load_cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_compute(input int abort_at);
    int exp_stg;
    comp_cyc = 0; fin_cnt = 0; flush_cnt = 0; stg_bad = 0; agu_bad = 0;
    while (busy && !in_ready && !out_valid && !done && comp_cyc < 20000) begin
      if (comp_cyc == abort_at) begin
        abort = 1'b1;
        #1;
        check("abort_cycle_agu_en", agu_en, 1);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("after_abort_outs", outs, 0);
        break;
      end
      #1;
      exp_stg = (comp_cyc < 16384) ? comp_cyc / 4096 : 4;
      if (stage_idx != exp_stg || fft_fin != (exp_stg == 3)) stg_bad++;
      if (!agu_en) agu_bad++;
      if (fft_fin) fin_cnt++;
      if (stage_idx == 4) flush_cnt++;
      comp_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_unload(input int max_cyc);
    unl_cyc = 0; wr_cnt = 0; wr_bad = 0;
    while (out_valid && unl_cyc < max_cyc) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (wrfd_en) wr_cnt++;
      if (wrfd_en != out_ready || agu_en || stage_idx != 0) wr_bad++;
      unl_cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    int bad;
    start = 0; abort = 0; in_valid = 0; out_ready = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_outs", outs, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (outs != 0) bad++;
      @(negedge clk);
    end
    check("idle_10_cycles_bad", bad, 0);

    //            start abort iv  or   expected
    vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0)};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 1, 0)};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, mk(1, 0, 1, 1, 1, 0)};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 1, 1, 0)};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, mk(1, 0, 1, 1, 1, 0)};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 1, 0)};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(1, 0, 0, 1, 1, 0)};
    vt[11] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 12; i++) begin
      start = vt[i].start; abort = vt[i].abort;
      in_valid = vt[i].in_valid; out_ready = vt[i].out_ready;
      #1;
      check($sformatf("vec%0d_outs", i), outs, vt[i].exp);
      @(negedge clk);
    end
    start = 0; abort = 0; in_valid = 0; out_ready = 0;

    // Transform 1: continuous load, full compute, then async reset mid-unload
    pulse_start();
    check("t1_busy_after_start", busy, 1);
    run_load(1'b0, 1'b0);
    check("t1_load_agu_pulses", load_pulses, 4096);
    check("t1_load_cycles", load_cyc, 4096);
    check("t1_load_bad", load_bad, 0);
    run_compute(-1);
    check("t1_comp_cycles", comp_cyc, 16432);
    check("t1_comp_stage_bad", stg_bad, 0);
    check("t1_comp_agu_bad", agu_bad, 0);
    check("t1_fft_fin_cycles", fin_cnt, 4096);
    check("t1_flush_cycles", flush_cnt, 48);
    run_unload(1000);
    check("t1_partial_unload_cycles", unl_cyc, 1000);
    check("t1_partial_unload_bad", wr_bad, 0);
    out_ready = 1'b1;
    #1;
    check("t1_pre_reset_wrfd_en", wrfd_en, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t1_async_reset_outs", outs, 0);
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("t1_after_reset_outs", outs, 0);
    @(negedge clk);

    // Transform 2: toggling load with start held, abort in compute at counter 5000
    pulse_start();
    run_load(1'b1, 1'b1);
    check("t2_load_agu_pulses", load_pulses, 4096);
    check("t2_load_cycles", load_cyc, 8192);
    check("t2_load_bad", load_bad, 0);
    run_compute(5000);
    check("t2_abort_at_cycle", comp_cyc, 5000);
    check("t2_stage_bad_before_abort", stg_bad, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (done || busy) bad++;
    end
    check("t2_no_done_after_abort", bad, 0);
    @(negedge clk);

    // Transform 3: full run with random unload back-pressure, start during DONE
    pulse_start();
    run_load(1'b0, 1'b0);
    check("t3_load_agu_pulses", load_pulses, 4096);
    run_compute(-1);
    check("t3_comp_cycles", comp_cyc, 16432);
    check("t3_fft_fin_cycles", fin_cnt, 4096);
    run_unload(20000);
    check("t3_wrfd_pulses", wr_cnt, 4096);
    check("t3_unload_bad", wr_bad, 0);
    start = 1'b1;
    #1;
    check("t3_done_pulse", done, 1);
    check("t3_done_busy", busy, 1);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("t3_done_width", done, 0);
    check("t3_idle_busy", busy, 0);
    check("t3_start_in_done_ignored", in_ready, 0);
    @(negedge clk);
    #1;
    check("t3_idle_outs", outs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/r16_fft_seq_ctrl.md
Name: r16_fft_seq_ctrl

Overview:
- Top-level sequencer for the radix-16 65536-point FFT datapath.
- Drives the address-generation unit's enable, row/column select, write-from-data enable and final-stage flag.
- Runs one transform as load (4096 words), 4-stage compute (incl. pipeline flush), unload (4096 words).
- Valid/ready handshakes on load and unload; start/done handshake toward the host.

Parameters:
- LOAD_LEN, 4096, load-phase word transfers (16 samples per word)
- COMP_LEN, 16432, compute-phase cycles (4 stages x 4096 + 48 flush), counted 0..16431
- UNLOAD_LEN, 4096, unload-phase word transfers
- CNT_WIDTH, 15, phase counter width; must hold COMP_LEN-1
- STG_WIDTH, 3, stage index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a transform
- abort  in  1  synchronous abort, returns to IDLE
- in_valid  in  1  load word available
- in_ready  out  1  controller accepts load word
- out_ready  in  1  downstream accepts unload word
- out_valid  out  1  unload word presented
- agu_en  out  1  advance AGU data counter
- rc_sel  out  1  1 = load addressing mode, 0 = compute mode
- wrfd_en  out  1  unload-phase read strobe to AGU/RDC counter
- fft_fin  out  1  final stage active (multiplier bypass)
- stage_idx  out  STG_WIDTH  current compute stage 0..4
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse at completion

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset state:
  - state=IDLE, counter=0.
  - Every output is 0: in_ready, out_valid, agu_en, rc_sel, wrfd_en, fft_fin, stage_idx, busy, done.
- FSM states: IDLE, LOAD, COMPUTE, UNLOAD, DONE. The state register and counter are flops.
- Decoded from the state register:
  - rc_sel: LOAD only.
  - in_ready: LOAD only.
  - out_valid: UNLOAD only.
  - busy: any state except IDLE.
  - done: DONE only (1 cycle).
- Gated by handshake (combinational, zero latency):
  - agu_en = (LOAD & in_valid) | COMPUTE.
  - wrfd_en = UNLOAD & out_ready.
- IDLE:
  - start=1 -> LOAD, counter cleared.
  - start is ignored while busy.
- LOAD:
  - Counter increments on each in_valid&in_ready.
  - On the transfer where counter==LOAD_LEN-1 -> COMPUTE, counter=0.
  - in_valid low stalls: no agu_en and no count.
- COMPUTE:
  - agu_en=1 every cycle; counter increments.
  - stage_idx = counter[14:12]; value 4 during the flush tail.
  - fft_fin=1 while stage_idx==3.
  - At counter==COMP_LEN-1 -> UNLOAD, counter=0.
- UNLOAD:
  - Counter increments on out_valid&out_ready.
  - out_ready low holds the count, with wrfd_en=0.
  - Last transfer (counter==UNLOAD_LEN-1) -> DONE.
- DONE: done=1 for one cycle -> IDLE. A start in this cycle is ignored.
- abort:
  - Any state except IDLE -> IDLE next cycle, counter cleared. No done pulse.
  - abort has priority over all transitions.
  - Simultaneous with a completing handshake, that handshake's agu_en/wrfd_en still asserts this cycle.
- Counter:
  - Unsigned, wraps never; it is cleared on every phase change.
  - stage_idx=0 outside COMPUTE; fft_fin=0 outside COMPUTE.
- Reset mid-operation: immediate return to reset values; no partial done.

Decomposition:
- Shared package r16_fft_pkg holds:
  - state enum (IDLE..DONE);
  - LOAD_LEN, COMP_LEN, UNLOAD_LEN, the 4096-cycle stage length;
  - the 48-cycle flush constant.
- One sub-module, r16_phase_cnt: loadable-clear up-counter with enable and terminal-count flag, instantiated once and shared across phases.
- FSM and output decode stay in the top.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, busy=0; start=1 -> busy=1 and rc_sel=in_ready=1 next cycle.
- Load with in_valid=1 continuously -> exactly 4096 agu_en pulses with rc_sel=1. Then COMPUTE with agu_en=1 for 16432 cycles:
  - stage_idx steps 0,1,2,3 every 4096 cycles, then 4 for 48 cycles;
  - fft_fin high for exactly 4096 cycles.
- Load with in_valid toggling 1/0 -> still exactly 4096 agu_en pulses; LOAD lasts 8192 cycles.
- Unload with out_ready random 50% -> exactly 4096 wrfd_en pulses, then done pulse of width 1, then busy=0.
- abort in COMPUTE at counter=5000 -> IDLE next cycle, agu_en=0, no done; a fresh start runs a full transform normally.
- rst_n low mid-UNLOAD -> outputs 0 asynchronously (before the next clk edge); start during busy and during DONE -> no effect.
